sprite_ahb_writer: RTL and testbench

SPRITE_AHB_WRITER -- requirements
Module: sprite_ahb_writer

---
 rtl/sprite_ahb_writer.sv | 128 ++++++++++++
 tb/tb_sprite_ahb_writer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_ahb_writer.sv
// rtl/sprite_ahb_writer.sv - AHB-Lite write master draining a sprite attribute command FIFO
module sprite_ahb_writer #(
  parameter int          ADDR_WIDTH = 6,
  parameter logic [31:0] BASE_ADDR  = 32'h5000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_index,
  input  logic [31:0]           cmd_data,
  output logic [31:0]           HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [31:0]           HWDATA,
  input  logic                  HREADY,
  input  logic                  HRESP,
  output logic                  busy,
  output logic                  err,
  input  logic                  err_clr
);

  // FIFO_DEPTH is a power of two >= 2, so pointers wrap naturally
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH+31:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [31:0]           r_haddr;
  logic [31:0]           r_hwdata;
  logic                  r_err;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_not_empty;
  logic                  w_addr_phase;
  logic [ADDR_WIDTH-1:0] w_head_index;
  logic [31:0]           w_head_data;
  logic [31:0]           w_head_addr;

  assign w_not_empty  = (r_count != '0);
  assign cmd_ready    = (r_count < DEPTH_C);
  assign w_push       = cmd_valid && cmd_ready;
  // The head is presented as an address phase except during the cancelling ERROR cycle
  assign w_addr_phase = w_not_empty && (r_state != S_ERR);
  assign w_pop        = w_addr_phase && HREADY;
  assign w_head_index = r_mem[r_rd_ptr][ADDR_WIDTH+31:32];
  assign w_head_data  = r_mem[r_rd_ptr][31:0];
  // Byte offset is zero-extended so the index can never carry into upper address bits
  assign w_head_addr  = BASE_ADDR + {{(30-ADDR_WIDTH){1'b0}}, w_head_index, 2'b00};

  assign HTRANS = w_addr_phase ? TR_NONSEQ : TR_IDLE;
  assign HADDR  = w_addr_phase ? w_head_addr : r_haddr;
  assign HWDATA = r_hwdata;
  assign HWRITE = 1'b1;
  assign HSIZE  = 3'b010;
  assign HBURST = 3'b000;
  assign HPROT  = 4'b0011;
  assign busy   = w_not_empty || (r_state != S_IDLE);
  assign err    = r_err;

  // Command storage; contents need no reset since the count gates visibility
  always_ff @(posedge HCLK) begin
    if (w_push) r_mem[r_wr_ptr] <= {cmd_index, cmd_data};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
    end
  end

  // Bus-side registers: held address, write data, sticky error
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_haddr  <= BASE_ADDR;
      r_hwdata <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_addr_phase) r_haddr <= w_head_addr;
      if (w_pop)        r_hwdata <= w_head_data;
      if ((r_state == S_DATA) && !HREADY && HRESP) r_err <= 1'b1;
      else if (err_clr)                            r_err <= 1'b0;
    end
  end

  // Transfer state register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state: data phase tracking and two-cycle ERROR handling
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_pop) w_state_nxt = S_DATA;
      S_DATA: begin
        if (HREADY)     w_state_nxt = w_pop ? S_DATA : S_IDLE;
        else if (HRESP) w_state_nxt = S_ERR;
      end
      S_ERR:  if (HREADY) w_state_nxt = S_IDLE;
      default:            w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sprite_ahb_writer.sv
// tb/tb_sprite_ahb_writer.sv - self-checking bench for sprite_ahb_writer
module tb_sprite_ahb_writer;

  localparam logic [31:0] BASE = 32'h5000_0000;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [5:0]  cmd_index = '0;
  logic [31:0] cmd_data = '0;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic        HREADY = 1'b1;
  logic        HRESP = 1'b0;
  logic        busy;
  logic        err;
  logic        err_clr = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  sprite_ahb_writer dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_index(cmd_index), .cmd_data(cmd_data), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP), .busy(busy), .err(err), .err_clr(err_clr)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] data;
    logic [31:0] exp_addr;
  } vec_t;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] data;
  } cmd_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0; HREADY = 1'b1; HRESP = 1'b0; err_clr = 1'b0;
    repeat (n) @(negedge HCLK);
  endtask

  task automatic push(input logic [5:0] idx, input logic [31:0] data);
    cmd_valid = 1'b1; cmd_index = idx; cmd_data = data;
  endtask

  vec_t vecs[6];
  cmd_t q[$];

  initial begin
    vecs[0] = '{6'd5,  32'hA5A5_0001, 32'h5000_0014};
    vecs[1] = '{6'd63, 32'h1234_5678, 32'h5000_00FC};
    vecs[2] = '{6'd0,  32'hFFFF_FFFF, 32'h5000_0000};
    vecs[3] = '{6'd42, 32'h0000_0000, 32'h5000_00A8};
    vecs[4] = '{6'd1,  32'hDEAD_BEEF, 32'h5000_0004};
    vecs[5] = '{6'd32, 32'h8000_0001, 32'h5000_0080};

    // reset state
    #12;
    check("rst_htrans", HTRANS, 2'b00);
    check("rst_haddr", HADDR, BASE);
    check("rst_hwdata", HWDATA, 32'h0);
    check("rst_err", err, 1'b0);
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("const_ctl", {HWRITE, HSIZE, HBURST, HPROT}, {1'b1, 3'b010, 3'b000, 4'b0011});
    @(negedge HCLK);
    HRESETn = 1'b1;
    idle(2);

    // single writes from the vector table
    for (int i = 0; i < 6; i++) begin
      push(vecs[i].idx, vecs[i].data);
      @(negedge HCLK);
      cmd_valid = 1'b0;
      check("vec_htrans", HTRANS, 2'b10);
      check("vec_haddr", HADDR, vecs[i].exp_addr);
      @(negedge HCLK);
      check("vec_hwdata", HWDATA, vecs[i].data);
      check("vec_busy_hi", busy, 1'b1);
      @(negedge HCLK);
      check("vec_busy_lo", busy, 1'b0);
      check("vec_idle", HTRANS, 2'b00);
      check("vec_haddr_hold", HADDR, vecs[i].exp_addr);
    end
    idle(1);

    // back-to-back pipelined writes
    for (int i = 0; i < 6; i++) begin
      if (i < 4) push(6'(i), 32'hB000_0000 + 32'(i));
      else cmd_valid = 1'b0;
      if (i >= 1 && i <= 4) begin
        check("b2b_htrans", HTRANS, 2'b10);
        check("b2b_haddr", HADDR, BASE + 32'(4 * (i - 1)));
      end
      if (i >= 2) check("b2b_hwdata", HWDATA, 32'hB000_0000 + 32'(i - 2));
      @(negedge HCLK);
    end
    idle(2);

    // full FIFO with bus stalled
    HREADY = 1'b0;
    for (int k = 0; k < 6; k++) begin
      push(6'(10 + (k < 4 ? k : 4)), 32'hC000_0000 + 32'(k < 4 ? k : 4));
      if (k >= 4) begin
        check("full_ready", cmd_ready, 1'b0);
        check("full_haddr", HADDR, BASE + 32'd40);
        check("full_hwdata", HWDATA, 32'hB000_0003);
      end
      @(negedge HCLK);
    end
    cmd_valid = 1'b0; HREADY = 1'b1;
    check("drain_haddr0", HADDR, BASE + 32'd40);
    for (int j = 1; j <= 5; j++) begin
      @(negedge HCLK);
      if (j < 4) check("drain_haddr", HADDR, BASE + 32'(4 * (10 + j)));
      if (j == 4) check("drain_idle", HTRANS, 2'b00);
      if (j <= 4) check("drain_hwdata", HWDATA, 32'hC000_0000 + 32'(j - 1));
      if (j == 5) check("drain_busy", busy, 1'b0);
    end
    idle(1);

    // ERROR response on the second transfer
    push(6'd20, 32'hE000_0000); @(negedge HCLK);
    check("err_a0", HADDR, BASE + 32'd80);
    push(6'd21, 32'hE000_0001); @(negedge HCLK);
    check("err_a1", HADDR, BASE + 32'd84);
    push(6'd22, 32'hE000_0002); @(negedge HCLK);
    cmd_valid = 1'b0; HREADY = 1'b0; HRESP = 1'b1;
    check("err_a2", HADDR, BASE + 32'd88);
    check("err_wd1", HWDATA, 32'hE000_0001);
    @(negedge HCLK);
    HREADY = 1'b1;
    check("err_set", err, 1'b1);
    check("err_cycle2_idle", HTRANS, 2'b00);
    check("err_busy", busy, 1'b1);
    @(negedge HCLK);
    HRESP = 1'b0;
    check("err_next_trans", HTRANS, 2'b10);
    check("err_next_addr", HADDR, BASE + 32'd88);
    check("err_wd_hold", HWDATA, 32'hE000_0001);
    @(negedge HCLK);
    check("err_wd2", HWDATA, 32'hE000_0002);
    check("err_sticky", err, 1'b1);
    err_clr = 1'b1;
    @(negedge HCLK);
    err_clr = 1'b0;
    check("err_cleared", err, 1'b0);
    push(6'd23, 32'hE000_0003); @(negedge HCLK);
    cmd_valid = 1'b0; @(negedge HCLK);
    HREADY = 1'b0; HRESP = 1'b1; err_clr = 1'b1;
    @(negedge HCLK);
    check("err_set_wins", err, 1'b1);
    HREADY = 1'b1; err_clr = 1'b0;
    @(negedge HCLK);
    HRESP = 1'b0; err_clr = 1'b1;
    @(negedge HCLK);
    err_clr = 1'b0;
    check("err_clr2", err, 1'b0);
    check("err_end_busy", busy, 1'b0);
    idle(1);

    // reset during a wait-stated data phase with three queued
    push(6'd30, 32'hF000_0000); @(negedge HCLK);
    push(6'd31, 32'hF000_0001); @(negedge HCLK);
    push(6'd32, 32'hF000_0002); HREADY = 1'b0; @(negedge HCLK);
    push(6'd33, 32'hF000_0003); @(negedge HCLK);
    cmd_valid = 1'b0;
    check("mid_busy", busy, 1'b1);
    #2 HRESETn = 1'b0;
    #1;
    check("mid_rst_htrans", HTRANS, 2'b00);
    check("mid_rst_haddr", HADDR, BASE);
    check("mid_rst_hwdata", HWDATA, 32'h0);
    check("mid_rst_ready", cmd_ready, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_err", err, 1'b0);
    @(negedge HCLK);
    HRESETn = 1'b1; HREADY = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge HCLK);
      check("post_rst_idle", {HTRANS, busy}, 3'b000);
    end

    // randomized traffic against a queue-based model
    begin
      logic        pending;
      logic [31:0] last_addr;
      logic [31:0] last_wdata;
      logic        exp_ready;
      logic        do_pop;
      q.delete();
      pending = 1'b0; last_addr = BASE; last_wdata = 32'h0;
      for (int c = 0; c < 400; c++) begin
        exp_ready = (q.size() < 4);
        if (q.size() != 0) last_addr = BASE + 32'(q[0].idx) * 4;
        check("rnd_ready", cmd_ready, exp_ready);
        check("rnd_htrans", HTRANS, (q.size() != 0) ? 2'b10 : 2'b00);
        check("rnd_haddr", HADDR, last_addr);
        check("rnd_hwdata", HWDATA, last_wdata);
        check("rnd_busy", busy, (q.size() != 0) || pending);
        cmd_valid = 1'($urandom);
        cmd_index = 6'($urandom);
        cmd_data  = $urandom;
        HREADY    = ($urandom_range(3, 0) != 0);
        do_pop = HREADY && (q.size() != 0);
        if (HREADY) pending = do_pop;
        if (do_pop) begin
          last_wdata = q[0].data;
          void'(q.pop_front());
        end
        if (cmd_valid && exp_ready) q.push_back('{cmd_index, cmd_data});
        @(negedge HCLK);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
